instruction_queue: RTL and testbench
====================================

# instruction_queue

Parametrised successor to the single-entry instruction register. It buffers up to DEPTH fetched instructions in a first-word-fall-through queue between program memory and the controller. The head entry is split into opcode and operand fields for decode, and the queue supports a single-cycle flush on control-flow changes.

## Interface
Parameters:
- OPCODE_W, 4, opcode field width (instruction MSBs)
- OPERAND_W, 4, operand/immediate field width (instruction LSBs)
- DEPTH, 4, queue entries; power of two, ≥2

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears queue at the next rising edge
- instruction  in  OPCODE_W+OPERAND_W  fetched word; opcode = [MSB -: OPCODE_W], operand = [OPERAND_W-1:0]
- in_valid  in  1  fetch side offers `instruction` this cycle
- in_ready  out  1  queue can accept (count < DEPTH)
- LoadIR  in  1  controller consumes head entry this cycle
- flush  in  1  discard all entries (branch/jump taken)
- opcode  out  OPCODE_W  head opcode; NOP (all zeros) when empty
- data_out  out  OPERAND_W  head operand; zero when empty
- out_valid  out  1  head entry valid (count > 0)
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry array, write pointer, read pointer, and occupancy counter. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Push: in_valid && in_ready, sampled at the edge. Writes the entry at wr_ptr and increments wr_ptr.
- Pop: LoadIR && out_valid. Increments rd_ptr.
- LoadIR while empty is ignored; no pointer or count change.
- in_valid while full is ignored; the word is dropped and fetch must hold it. in_ready = 0 signals this.
- Push and pop in the same cycle: both occur and count is unchanged. Applies with 0 < count < DEPTH.
  - Full + pop + in_valid: only the pop occurs, because in_ready was 0.
  - Empty + push + LoadIR: only the push occurs.
- Flush: sets wr_ptr = rd_ptr = 0 and count = 0 at the next edge. Overrides any simultaneous push and pop; the pushed word is discarded.
- Reset: same effect as flush. Reset has priority over flush, push, and pop.
- Outputs:
  - opcode/data_out are combinational from mem[rd_ptr] when out_valid, otherwise forced to 0 (NOP).
  - in_ready and out_valid are decoded from the count register only. There is no combinational path from LoadIR or in_valid to any output.
- Count arithmetic: count_next = count + push − pop. It must never exceed DEPTH or go below 0; assertion-checked.

## Timing
- Reset values: count = 0, out_valid = 0, in_ready = 1, opcode = 0, data_out = 0.
- Push-to-visibility latency is 1 cycle. A word accepted at edge N appears on opcode/data_out with out_valid = 1 after edge N, if the queue was empty.
- Pop is effective at the edge. The next entry, or NOP if the queue is now empty, is presented in the following cycle.
- Sustained throughput is 1 push and 1 pop per cycle for any count from 1 to DEPTH−1.
- Flush and reset take effect 1 cycle after assertion. out_valid = 0 and in_ready = 1 in the cycle after.

## Structure
- Shared package `cpu_pkg`:
  - OPCODE_W/OPERAND_W defaults
  - NOP opcode constant (4'b0000)
  - instruction field-extract helpers
- One natural sub-module, `iq_storage`: a DEPTH × (OPCODE_W+OPERAND_W) register array with one write port (we, waddr, wdata) and one async read address. Pointer, count, and flush control stay in `instruction_queue`.
- The existing instruction register port names (opcode, data_out, LoadIR) are kept so the controller connects unchanged.

## Test plan
- Reset: hold reset 2 cycles with in_valid = 1 → count = 0, out_valid = 0, opcode = 0, data_out = 0, in_ready = 1. No entry is written.
- Fill/drain, DEPTH = 4: push 0x12, 0x34, 0x56, 0x78 on consecutive cycles → count = 4, in_ready = 0, head = 0x1/0x2. Push 0x9A while full → dropped. Pop 4 times → outputs 0x1/2, 0x3/4, 0x5/6, 0x7/8, then NOP with out_valid = 0.
- Wrap-around: sustain 10 cycles of simultaneous push and pop at count = 2 → FIFO order preserved across pointer wrap; count stays 2.
- Flush: count = 3, assert flush together with a push of 0xAB and LoadIR → next cycle count = 0, out_valid = 0, and 0xAB is never observed.
- Boundaries: LoadIR on empty → no change. Full + LoadIR + in_valid → count = 3 and the new word is not accepted. Empty + push + LoadIR → count = 1 and the head is the new word.
- Reset mid-operation: count = 2, assert reset and flush together → reset state next cycle. The queue then accepts 0x5C → opcode = 0x5, data_out = 0xC.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: default instruction field widths, the NOP opcode,
// and field-extract helpers for an instruction word of any width up to
// MAX_INSTR_W bits. The helpers take widths as arguments; callers pass
// elaboration-time constants, so they reduce to plain bit selects.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned DEF_OPCODE_W  = 4;
    localparam int unsigned DEF_OPERAND_W = 4;

    localparam logic [DEF_OPCODE_W-1:0] NOP_OPCODE = 4'b0000;

    localparam int unsigned MAX_INSTR_W = 64;
    localparam int unsigned MAX_FIELD_W = 32;

    // Low field_w bits of the word (operand field).
    function automatic logic [MAX_FIELD_W-1:0] extract_lo(
        input logic [MAX_INSTR_W-1:0] word,
        input int unsigned            field_w
    );
        logic [MAX_INSTR_W-1:0] mask;
        mask = (MAX_INSTR_W'(1) << field_w) - MAX_INSTR_W'(1);
        return MAX_FIELD_W'(word & mask);
    endfunction

    // Top field_w bits of a total_w-bit word (opcode field).
    function automatic logic [MAX_FIELD_W-1:0] extract_hi(
        input logic [MAX_INSTR_W-1:0] word,
        input int unsigned            total_w,
        input int unsigned            field_w
    );
        return extract_lo(word >> (total_w - field_w), field_w);
    endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// ---------------------------------------------------------------------------
// instruction_queue_if
// Bundles the fetch-side and controller-side signals of the instruction
// queue. Port names of the former instruction register (opcode, data_out,
// LoadIR) are kept so the controller hookup is unchanged.
//   master : fetch/controller side (drives instruction, in_valid, LoadIR, flush)
//   slave  : the queue (drives in_ready, opcode, data_out, out_valid, count)
// ---------------------------------------------------------------------------
interface instruction_queue_if
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W  = DEF_OPCODE_W,
    parameter int unsigned OPERAND_W = DEF_OPERAND_W,
    parameter int unsigned DEPTH     = 4
);
    logic [OPCODE_W+OPERAND_W-1:0] instruction;
    logic                          in_valid;
    logic                          in_ready;
    logic                          LoadIR;
    logic                          flush;
    logic [OPCODE_W-1:0]           opcode;
    logic [OPERAND_W-1:0]          data_out;
    logic                          out_valid;
    logic [$clog2(DEPTH+1)-1:0]    count;

    modport master (
        output instruction, in_valid, LoadIR, flush,
        input  in_ready, opcode, data_out, out_valid, count
    );

    modport slave (
        input  instruction, in_valid, LoadIR, flush,
        output in_ready, opcode, data_out, out_valid, count
    );
endinterface

// File: rtl/iq_storage.sv
// ---------------------------------------------------------------------------
// iq_storage
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. No reset: entry contents are only meaningful
// when the owning queue marks them valid.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
// ---------------------------------------------------------------------------
module iq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instruction_queue.sv
// ---------------------------------------------------------------------------
// instruction_queue
// First-word-fall-through queue of DEPTH fetched instructions between
// program memory and the controller. The head entry is presented split into
// opcode/operand; an empty queue presents NOP. flush empties the queue in
// one cycle on control-flow changes.
//   clock : rising-edge clock
//   reset : synchronous, active-high; same effect as flush, highest priority
//   bus   : instruction_queue_if.slave (fetch + controller signals)
// ---------------------------------------------------------------------------
module instruction_queue
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W  = DEF_OPCODE_W,
    parameter int unsigned OPERAND_W = DEF_OPERAND_W,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                clock,
    input  logic                reset,
    instruction_queue_if.slave  bus
);
    localparam int unsigned INSTR_W = OPCODE_W + OPERAND_W;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               push, pop;
    logic               in_ready, out_valid;
    logic [INSTR_W-1:0] head_word;

    // Handshake status comes only from the count register, never from
    // in_valid/LoadIR, so no combinational path crosses the queue.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);

    assign push = bus.in_valid && in_ready;
    assign pop  = bus.LoadIR && out_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Occupancy must stay within 0..DEPTH; an underflow wraps above DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_d <= CNT_W'(DEPTH));
        end
    end

    // A word pushed alongside flush or reset is discarded, so don't store it.
    iq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_storage (
        .clk_i   (clock),
        .we_i    (push && !bus.flush && !reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.instruction),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_word)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.count     = count_q;
    assign bus.opcode    = out_valid
                         ? OPCODE_W'(extract_hi(MAX_INSTR_W'(head_word), INSTR_W, OPCODE_W))
                         : OPCODE_W'(NOP_OPCODE);
    assign bus.data_out  = out_valid
                         ? OPERAND_W'(extract_lo(MAX_INSTR_W'(head_word), OPERAND_W))
                         : '0;
endmodule

// File: tb/tb_instruction_queue.sv
// ---------------------------------------------------------------------------
// tb_instruction_queue
// Directed and random stimulus for instruction_queue (DEPTH = 4, 4/4-bit
// fields), compared every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_instruction_queue;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;

    instruction_queue_if #(.OPCODE_W(4), .OPERAND_W(4), .DEPTH(DEPTH)) bus ();

    instruction_queue #(.OPCODE_W(4), .OPERAND_W(4), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mdl [$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mdl.size();
        check({tag, " count"},     32'(bus.count),     32'(sz));
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(sz > 0));
        check({tag, " in_ready"},  32'(bus.in_ready),  32'(sz < DEPTH));
        check({tag, " opcode"},    32'(bus.opcode),    (sz > 0) ? 32'(mdl[0][7:4]) : 32'h0);
        check({tag, " data_out"},  32'(bus.data_out),  (sz > 0) ? 32'(mdl[0][3:0]) : 32'h0);
    endtask

    // Drive one cycle of inputs, advance the model by the queue's rules,
    // then compare just after the edge.
    task automatic cycle(input logic iv, input logic [7:0] w, input logic ld,
                         input logic fl, input logic rs, input string tag);
        int  sz;
        bit  do_push, do_pop;
        bus.in_valid    = iv;
        bus.instruction = w;
        bus.LoadIR      = ld;
        bus.flush       = fl;
        reset           = rs;
        sz = mdl.size();
        if (rs || fl) begin
            mdl.delete();
        end else begin
            do_push = iv && (sz < DEPTH);
            do_pop  = ld && (sz > 0);
            if (do_pop)  void'(mdl.pop_front());
            if (do_push) mdl.push_back(w);
        end
        @(posedge clock);
        #1;
        check_model(tag);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.instruction = '0;
        bus.LoadIR      = 1'b0;
        bus.flush       = 1'b0;
        reset           = 1'b1;

        // Reset held two cycles with in_valid asserted
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, "rst1");
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, "rst2");
        check("rst in_ready", 32'(bus.in_ready), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "post_rst");
        check("post_rst no entry", 32'(bus.out_valid), 32'h0);

        // Fill / drain
        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, "fill0");
        check("first push visible op", 32'(bus.opcode), 32'h1);
        cycle(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, "fill1");
        cycle(1'b1, 8'h56, 1'b0, 1'b0, 1'b0, "fill2");
        cycle(1'b1, 8'h78, 1'b0, 1'b0, 1'b0, "fill3");
        check("full count", 32'(bus.count), 32'h4);
        check("full in_ready", 32'(bus.in_ready), 32'h0);
        check("full head data", 32'(bus.data_out), 32'h2);
        cycle(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, "push_full");
        check("push_full count", 32'(bus.count), 32'h4);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop0");
        check("pop0 head", 32'({bus.opcode, bus.data_out}), 32'h34);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop1");
        check("pop1 head", 32'({bus.opcode, bus.data_out}), 32'h56);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop2");
        check("pop2 head", 32'({bus.opcode, bus.data_out}), 32'h78);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop3");
        check("drained out_valid", 32'(bus.out_valid), 32'h0);
        check("drained nop", 32'({bus.opcode, bus.data_out}), 32'h00);

        // Wrap-around at count = 2 with simultaneous push/pop
        cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, "wrap_pre0");
        cycle(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, "wrap_pre1");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0, "wrap");
        end
        check("wrap count", 32'(bus.count), 32'h2);
        check("wrap head", 32'({bus.opcode, bus.data_out}), 32'hC8);

        // Flush at count = 3 with push 0xAB and LoadIR
        cycle(1'b1, 8'hD3, 1'b0, 1'b0, 1'b0, "flush_pre");
        check("flush_pre count", 32'(bus.count), 32'h3);
        cycle(1'b1, 8'hAB, 1'b1, 1'b1, 1'b0, "flush");
        check("flush count", 32'(bus.count), 32'h0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "flush_after");
        check("flush AB dropped", 32'(bus.out_valid), 32'h0);

        // Boundaries
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "pop_empty");
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0, "refill");
        end
        cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, "full_pop_push");
        check("full_pop_push count", 32'(bus.count), 32'h3);
        check("full_pop_push in_ready", 32'(bus.in_ready), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush2");
        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, "empty_push_pop");
        check("empty_push_pop count", 32'(bus.count), 32'h1);
        check("empty_push_pop head", 32'({bus.opcode, bus.data_out}), 32'h3C);

        // Reset together with flush mid-operation
        cycle(1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, "mid_pre");
        check("mid_pre count", 32'(bus.count), 32'h2);
        cycle(1'b1, 8'hEF, 1'b1, 1'b1, 1'b1, "mid_rst");
        check("mid_rst count", 32'(bus.count), 32'h0);
        check("mid_rst in_ready", 32'(bus.in_ready), 32'h1);
        cycle(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, "after_rst");
        check("after_rst opcode", 32'(bus.opcode), 32'h5);
        check("after_rst data", 32'(bus.data_out), 32'hC);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7,
                  8'($urandom),
                  $urandom_range(0, 9) < 5,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 49) == 0,
                  "random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
